// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump engine.
//   - state_t        : dump FSM states (ST_IDX is only reachable when
//                      REGDUMP_INDEX_EN is defined)
//   - BYTES_PER_WORD : bytes streamed per 32-bit register
//   - REG_IDX_W      : width of an architectural register index
//   - BYTE_CNT_W     : width of the per-word byte counter
package regdump_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int REG_IDX_W      = 5;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_IDX,
        ST_SEND,
        ST_FIN
    } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Splits a 32-bit word into bytes, least-significant byte first, and
// presents them on a valid/ready handshake.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   load      : capture word into the shift register, clear the byte count
//   word      : 32-bit value to serialize
//   enable    : owner permits presentation of the current byte
//   ready     : consumer accepts the byte this cycle
//   data      : current byte (shift[7:0])
//   valid     : data is valid (follows enable, never depends on ready)
//   last      : the byte currently presented is the final one of the word
module word_byte_serializer
    import regdump_pkg::*;
(
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        load,
    input  logic [8*BYTES_PER_WORD-1:0] word,
    input  logic                        enable,
    input  logic                        ready,
    output logic [7:0]                  data,
    output logic                        valid,
    output logic                        last
);

    logic [8*BYTES_PER_WORD-1:0] shift;
    logic [BYTE_CNT_W-1:0]       count;
    logic                        fire;

    assign valid = enable;
    assign fire  = enable && ready;
    assign data  = shift[7:0];
    assign last  = (count == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; the shift register is reset too, because its
    // low byte is the visible tx_data and must read 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift <= '0;
            count <= '0;
        end else if (load) begin
            shift <= word;
            count <= '0;
        end else if (fire) begin
            shift <= shift >> 8;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_dumper.sv
// Debug read-out engine: on start, sweeps registers FIRST_REG..LAST_REG
// through a spare asynchronous read port and streams each value as
// little-endian bytes over a valid/ready byte interface.
// Build option: define REGDUMP_INDEX_EN to prefix every register's data
// bytes with an index byte {3'b000, idx}.
// Parameters: FIRST_REG, LAST_REG (FIRST_REG <= LAST_REG <= 31).
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   start     : one-cycle dump request, honoured only in IDLE
//   busy      : dump in progress (LOAD/IDX/SEND)
//   done      : one-cycle pulse after the last byte handshake
//   rf_addr   : register index to the read port (always equals idx)
//   rf_data   : combinational read data for rf_addr
//   tx_data   : byte to the transmitter
//   tx_valid  : tx_data valid
//   tx_ready  : transmitter accepts the byte
module regfile_dumper
    import regdump_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [REG_IDX_W-1:0] rf_addr,
    input  logic [31:0]          rf_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    state_t               state;
    logic [REG_IDX_W-1:0] idx;
    logic                 ser_load;
    logic                 ser_enable;
    logic [7:0]           ser_data;
    logic                 ser_valid;
    logic                 ser_last;

    assign rf_addr    = idx;
    assign ser_load   = (state == ST_LOAD);
    assign ser_enable = (state == ST_SEND);

    word_byte_serializer u_serializer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (ser_load),
        .word   (rf_data),
        .enable (ser_enable),
        .ready  (tx_ready),
        .data   (ser_data),
        .valid  (ser_valid),
        .last   (ser_last)
    );

`ifdef REGDUMP_INDEX_EN
    assign tx_valid = ser_valid || (state == ST_IDX);
    assign tx_data  = (state == ST_IDX) ? {{(8-REG_IDX_W){1'b0}}, idx} : ser_data;
`else
    assign tx_valid = ser_valid;
    assign tx_data  = ser_data;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            idx   <= FIRST_IDX;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idx <= FIRST_IDX;
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                // rf_data is captured by the serializer on the edge leaving LOAD.
                ST_LOAD: begin
`ifdef REGDUMP_INDEX_EN
                    state <= ST_IDX;
`else
                    state <= ST_SEND;
`endif
                end
`ifdef REGDUMP_INDEX_EN
                ST_IDX: begin
                    if (tx_ready) state <= ST_SEND;
                end
`endif
                ST_SEND: begin
                    if (tx_ready && ser_last) begin
                        // Stop at LAST_REG; idx never advances past it.
                        if (idx == LAST_IDX) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                // A start arriving here is dropped, not queued.
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper. A behavioural register file with
// write-first read-during-write feeds a full-range instance (0..31) and a
// single-register instance (6..6). Expected byte streams are produced from
// the register contents by a queue model; handshakes are observed on the
// falling clock edge. Honours REGDUMP_INDEX_EN when defined.
module tb_regfile_dumper;

`ifdef REGDUMP_INDEX_EN
    localparam int IDX_BYTES = 1;
`else
    localparam int IDX_BYTES = 0;
`endif
    localparam int BPR      = 4 + IDX_BYTES;   // bytes per register
    localparam int P        = BPR + 1;         // cycles per register at full rate
    localparam int NREG     = 32;
    localparam int DONE_OFF = NREG * P;        // cycles from first LOAD to done

    logic        clk;
    logic        rstn;
    logic        start, start6;
    logic        tx_ready, ready6;
    logic        busy, done, tx_valid;
    logic        busy6, done6, valid6;
    logic [4:0]  rf_addr, addr6;
    logic [31:0] rf_data, rdata6;
    logic [7:0]  tx_data, data6;

    logic [31:0] rf [32];
    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        rand_mode;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [7:0]  got[$];
    logic [7:0]  got6[$];
    logic [7:0]  exp_q[$];
    int          done_count = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    int          done6_count = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    // Write-first register file: a write in the same cycle is forwarded.
    assign rf_data = (cpu_we && cpu_waddr == rf_addr) ? cpu_wdata : rf[rf_addr];
    assign rdata6  = rf[addr6];

    regfile_dumper #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    regfile_dumper #(.FIRST_REG(6), .LAST_REG(6)) dut6 (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start6),
        .busy     (busy6),
        .done     (done6),
        .rf_addr  (addr6),
        .rf_data  (rdata6),
        .tx_data  (data6),
        .tx_valid (valid6),
        .tx_ready (ready6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake, done and hold-stability monitor for the full-range instance.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (valid6 && ready6) got6.push_back(data6);
            if (done6) done6_count++;
        end
    end

    // Ready driver: held high, or high with 30% probability per cycle.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference stream: optional index byte, then the word LSB first.
    task automatic build_expected(input int first, input int last);
        exp_q.delete();
        for (int r = first; r <= last; r++) begin
            if (IDX_BYTES == 1) exp_q.push_back(8'(r));
            for (int b = 0; b < 4; b++) exp_q.push_back(rf[r][8*b +: 8]);
        end
    endtask

    task automatic compare_q(input string tag, input logic [7:0] act[$], input int base);
        check({tag, "_len"}, 32'(act.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < act.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(act[base + i]), 32'(exp_q[i]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base_done, input int budget);
        int n = 0;
        while (done_count == base_done && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_count != base_done), 32'd1);
    endtask

    initial begin
        int hs_base, db, k0, db6, base6, n;
        rstn = 1'b0; start = 1'b0; start6 = 1'b0; ready6 = 1'b1;
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0; rand_mode = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom();
        rf[1]  = 32'h11223344;
        rf[31] = 32'hDEADBEEF;
        rf[6]  = 32'h000000A5;

        // Reset values.
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_addr6", 32'(addr6), 32'd6);
        rstn = 1'b1;
        step();

        // Full dump, ready held high; restarts mid-dump and in FIN; CPU write in r5's LOAD.
        hs_base = got.size();
        db = done_count;
        start = 1'b1;
        step();
        start = 1'b0;
        k0 = cyc;
        check("load_busy", 32'(busy), 32'd1);
        check("load_valid", 32'(tx_valid), 32'd0);
        check("load_addr", 32'(rf_addr), 32'd0);
        for (int c = 1; c <= DONE_OFF + 10; c++) begin
            step();
            if (c == 1) check("first_valid", 32'(tx_valid), 32'd1);
            start = (c == 50 || c == DONE_OFF);
            if (c == 100) check("mid_busy", 32'(busy), 32'd1);
            if (c == 5 * P) begin
                check("r5_load_addr", 32'(rf_addr), 32'd5);
                cpu_we = 1'b1; cpu_waddr = 5'd5; cpu_wdata = 32'hCAFEF00D;
            end else if (c == 5 * P + 1) begin
                rf[5] = cpu_wdata;
                cpu_we = 1'b0;
            end
            if (c == DONE_OFF) check("fin_done", 32'(done), 32'd1);
        end
        check("a_done_count", 32'(done_count - db), 32'd1);
        check("a_done_latency", 32'(done_cyc - k0), 32'(DONE_OFF));
        check("a_done_after_hs", 32'(done_cyc - last_hs_cyc), 32'd1);
        check("a_idle_busy", 32'(busy), 32'd0);
        build_expected(0, 31);
        compare_q("a_stream", got, hs_base);

        // Same dump under random backpressure.
        rand_mode = 1'b1;
        hs_base = got.size();
        db = done_count;
        pulse_start();
        wait_done("b", db, 5000);
        rand_mode = 1'b0;
        repeat (3) step();
        check("b_done_count", 32'(done_count - db), 32'd1);
        compare_q("b_stream", got, hs_base);

        // Single-register instance.
        base6 = got6.size();
        db6 = done6_count;
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        n = 0;
        while (done6_count == db6 && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        check("c_done_count", 32'(done6_count - db6), 32'd1);
        build_expected(6, 6);
        compare_q("c_stream", got6, base6);

        // Asynchronous reset during the third data byte of r10, then a fresh dump.
        pulse_start();
        for (int c = 1; c <= 10 * P + 1 + IDX_BYTES + 2; c++) step();
        check("d_byte3_valid", 32'(tx_valid), 32'd1);
        check("d_byte3_data", 32'(tx_data), 32'(rf[10][23:16]));
        rstn = 1'b0;
        #1;
        check("d_rst_valid", 32'(tx_valid), 32'd0);
        check("d_rst_busy", 32'(busy), 32'd0);
        check("d_rst_data", 32'(tx_data), 32'd0);
        check("d_rst_addr", 32'(rf_addr), 32'd0);
        step();
        rstn = 1'b1;
        repeat (3) step();
        check("d_idle_busy", 32'(busy), 32'd0);
        hs_base = got.size();
        db = done_count;
        pulse_start();
        wait_done("d", db, 1000);
        repeat (3) step();
        build_expected(0, 31);
        compare_q("d_stream", got, hs_base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
